execute: RTL
============

Name: execute

Overview:
- EX stage of the 5-stage pipeline; sits directly upstream of the Memory stage and drives all of its inputs.
- Selects forwarded operands, decodes the ALU operation, computes the ALU result, the branch condition and the branch target.
- Latches everything into the EX/MEM pipeline register, with stall and flush support.

Parameters:
- XLEN, 32, datapath width for operands, PC and results.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears pipeline register on the next rising clk edge
- stall  in  1  hold EX/MEM register contents
- flush  in  1  insert bubble (zero all outputs)
- Ctl_ALUSrc_in  in  1  0: operand B = forwarded rs2; 1: operand B = Immediate_in
- Ctl_ALUOpcode_in  in  2  00 add, 01 branch compare, 10 funct decode, 11 pass B
- Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in  in  1 each  controls passed to MEM
- PC_in  in  XLEN  PC of instruction in EX
- ReadData1_in, ReadData2_in  in  XLEN  register-file rs1/rs2 values
- Immediate_in  in  XLEN  sign-extended immediate, byte offset
- funct7_in  in  7  instruction funct7
- funct3_in  in  3  instruction funct3
- Rd_in  in  5  destination register
- ForwardA_in, ForwardB_in  in  2  00 regfile, 10 mem_data, 01 wb_data, 11 treated as 00
- mem_data  in  XLEN  ALU result currently in EX/MEM
- wb_data  in  XLEN  value being written back
- Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out, Ctl_MemWrite_out, Ctl_Branch_out  out  1 each  registered controls
- Rd_out  out  5  registered Rd
- Write_Data  out  XLEN  registered forwarded rs2, the store data
- ALUresult_out  out  XLEN  registered ALU result
- Zero_out  out  1  registered branch-condition-true flag
- PCimm_out  out  XLEN  registered PC_in + Immediate_in

Behaviour:
- Operand selection:
  - A = fwd(ForwardA_in, ReadData1_in).
  - Bf = fwd(ForwardB_in, ReadData2_in).
  - B = Ctl_ALUSrc_in ? Immediate_in : Bf.
- Ctl_ALUOpcode_in = 00: result = A+B.
- Ctl_ALUOpcode_in = 01: result = A-B; Zero by funct3:
  - 000 A==B
  - 001 A!=B
  - 100 signed A<B
  - 101 signed A>=B
  - 110 unsigned A<B
  - 111 unsigned A>=B
  - 010/011: Zero=0
- Ctl_ALUOpcode_in = 10, decoded by funct3:
  - 000: sub if funct7[5]=1 and ALUSrc=0, else add
  - 001: sll
  - 010: slt
  - 011: sltu
  - 100: xor
  - 101: sra if funct7[5], else srl
  - 110: or
  - 111: and
  - Shift amount = B[4:0].
  - slt/sltu results are 0 or 1, zero-extended.
- Ctl_ALUOpcode_in = 11: result = B (LUI).
- Zero for opcodes other than 01: 1 when result == 0.
- Arithmetic is modulo 2^XLEN; overflow is ignored. PCimm wraps modulo 2^XLEN.
- Latency: exactly 1 cycle; outputs reflect inputs sampled at the previous rising edge.
- Priority at each rising edge: reset > flush > stall > normal load.
- reset: all outputs = 0 (controls, Rd_out, Write_Data, ALUresult_out, Zero_out, PCimm_out). Applies mid-operation and overrides stall.
- flush: all outputs = 0 on that edge, so MEM sees a bubble with no write, no branch and no memory access. Flush overrides stall.
- stall, with no flush or reset: all outputs hold their previous values. Inputs presented during stall are lost.
- Simultaneous stall and flush: bubble is inserted.
- Ctl_Branch_out and Zero_out are registered independently. MEM forms PCSrc from their AND.

Test Plan:
- Reset held 2 cycles while inputs are nonzero -> every output is 0. Deassert with ALUOp=00, A=5, Imm=12, ALUSrc=1, MemWrite=1, rs2=4 -> next edge: ALUresult_out=17, Write_Data=4, Ctl_MemWrite_out=1.
- ALUOp=10, funct3=000, funct7=0100000, ALUSrc=0, A=7, B=12 -> ALUresult_out=0xFFFFFFFB, Zero_out=0. funct3=101 with funct7[5]=1, A=0x80000000, B=4 -> 0xF8000000.
- Branch: ALUOp=01, funct3=000, A=B=9, Branch=1, PC_in=20, Imm=12 -> Zero_out=1, Ctl_Branch_out=1, PCimm_out=32. funct3=100, A=-1, B=1 -> Zero_out=1. funct3=110, same operands -> Zero_out=0.
- Forwarding: ReadData1_in=1, mem_data=40, wb_data=50. ForwardA_in=10 -> A=40; ForwardA_in=01 -> A=50; ForwardA_in=11 -> A=1. Check each via ALUOp=11-independent add of B=0.
- Stall for 2 cycles while inputs change -> outputs unchanged. Release stall -> new values appear after 1 edge. Assert stall+flush together -> all outputs 0.
- Reset asserted in the middle of a stall with RegWrite=1 held -> outputs 0 at that edge. Deassert -> normal load resumes on the next edge.

Source files
------------

// File: rtl/execute.sv
// EX stage of the 5-stage pipeline.
// Forwards operands, runs the ALU and the branch comparator, and computes
// the branch target. Everything is captured in the EX/MEM pipeline
// register, which supports stall (hold) and flush (bubble).
module execute #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,

    // Control from ID/EX
    input  logic            Ctl_ALUSrc_in,
    input  logic [1:0]      Ctl_ALUOpcode_in,
    input  logic            Ctl_MemtoReg_in,
    input  logic            Ctl_RegWrite_in,
    input  logic            Ctl_MemRead_in,
    input  logic            Ctl_MemWrite_in,
    input  logic            Ctl_Branch_in,

    // Data from ID/EX
    input  logic [XLEN-1:0] PC_in,
    input  logic [XLEN-1:0] ReadData1_in,
    input  logic [XLEN-1:0] ReadData2_in,
    input  logic [XLEN-1:0] Immediate_in,
    input  logic [6:0]      funct7_in,
    input  logic [2:0]      funct3_in,
    input  logic [4:0]      Rd_in,

    // Forwarding
    input  logic [1:0]      ForwardA_in,
    input  logic [1:0]      ForwardB_in,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] wb_data,

    // EX/MEM register outputs
    output logic            Ctl_MemtoReg_out,
    output logic            Ctl_RegWrite_out,
    output logic            Ctl_MemRead_out,
    output logic            Ctl_MemWrite_out,
    output logic            Ctl_Branch_out,
    output logic [4:0]      Rd_out,
    output logic [XLEN-1:0] Write_Data,
    output logic [XLEN-1:0] ALUresult_out,
    output logic            Zero_out,
    output logic [XLEN-1:0] PCimm_out
);

    // ALU operation classes coming from the main decoder
    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_FUNCT  = 2'b10;
    localparam logic [1:0] OP_PASSB  = 2'b11;

    // Forwarding source encodings; 11 is unused and falls back to the regfile
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_bf;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic [4:0]      w_shamt;
    logic            w_eq;
    logic            w_lt_s;
    logic            w_lt_u;
    logic [XLEN-1:0] w_result;
    logic            w_branch_cond;
    logic            w_zero;
    logic [XLEN-1:0] w_pcimm;

    // Operand A forwarding mux
    always_comb begin
        w_op_a = ReadData1_in;
        case (ForwardA_in)
            FWD_MEM: w_op_a = mem_data;
            FWD_WB:  w_op_a = wb_data;
            default: w_op_a = ReadData1_in;
        endcase
    end

    // Operand B forwarding mux; this value is also the store data
    always_comb begin
        w_op_bf = ReadData2_in;
        case (ForwardB_in)
            FWD_MEM: w_op_bf = mem_data;
            FWD_WB:  w_op_bf = wb_data;
            default: w_op_bf = ReadData2_in;
        endcase
    end

    assign w_op_b  = Ctl_ALUSrc_in ? Immediate_in : w_op_bf;
    assign w_sum   = w_op_a + w_op_b;
    assign w_diff  = w_op_a - w_op_b;
    assign w_shamt = w_op_b[4:0];
    assign w_eq    = (w_op_a == w_op_b);
    assign w_lt_s  = ($signed(w_op_a) < $signed(w_op_b));
    assign w_lt_u  = (w_op_a < w_op_b);
    assign w_pcimm = PC_in + Immediate_in;

    // ALU result selection by operation class and funct fields
    always_comb begin
        w_result = '0;
        case (Ctl_ALUOpcode_in)
            OP_ADD:    w_result = w_sum;
            OP_BRANCH: w_result = w_diff;
            OP_FUNCT: begin
                case (funct3_in)
                    // Immediate forms never subtract: there is no subi
                    3'b000:  w_result = (funct7_in[5] && !Ctl_ALUSrc_in) ? w_diff : w_sum;
                    3'b001:  w_result = w_op_a << w_shamt;
                    3'b010:  w_result = {{(XLEN-1){1'b0}}, w_lt_s};
                    3'b011:  w_result = {{(XLEN-1){1'b0}}, w_lt_u};
                    3'b100:  w_result = w_op_a ^ w_op_b;
                    3'b101:  w_result = funct7_in[5] ? XLEN'($signed(w_op_a) >>> w_shamt)
                                                     : (w_op_a >> w_shamt);
                    3'b110:  w_result = w_op_a | w_op_b;
                    default: w_result = w_op_a & w_op_b;
                endcase
            end
            default:   w_result = w_op_b;
        endcase
    end

    // Branch comparator, only meaningful for the branch operation class
    always_comb begin
        w_branch_cond = 1'b0;
        case (funct3_in)
            3'b000:  w_branch_cond = w_eq;
            3'b001:  w_branch_cond = !w_eq;
            3'b100:  w_branch_cond = w_lt_s;
            3'b101:  w_branch_cond = !w_lt_s;
            3'b110:  w_branch_cond = w_lt_u;
            3'b111:  w_branch_cond = !w_lt_u;
            default: w_branch_cond = 1'b0;
        endcase
    end

    // Branches report the condition; everything else reports result == 0
    assign w_zero = (Ctl_ALUOpcode_in == OP_BRANCH) ? w_branch_cond : (w_result == '0);

    // EX/MEM pipeline register: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            Ctl_MemtoReg_out <= 1'b0;
            Ctl_RegWrite_out <= 1'b0;
            Ctl_MemRead_out  <= 1'b0;
            Ctl_MemWrite_out <= 1'b0;
            Ctl_Branch_out   <= 1'b0;
            Rd_out           <= '0;
            Write_Data       <= '0;
            ALUresult_out    <= '0;
            Zero_out         <= 1'b0;
            PCimm_out        <= '0;
        end else if (!stall) begin
            Ctl_MemtoReg_out <= Ctl_MemtoReg_in;
            Ctl_RegWrite_out <= Ctl_RegWrite_in;
            Ctl_MemRead_out  <= Ctl_MemRead_in;
            Ctl_MemWrite_out <= Ctl_MemWrite_in;
            Ctl_Branch_out   <= Ctl_Branch_in;
            Rd_out           <= Rd_in;
            Write_Data       <= w_op_bf;
            ALUresult_out    <= w_result;
            Zero_out         <= w_zero;
            PCimm_out        <= w_pcimm;
        end
    end

endmodule
